// File: rtl/config_accumulator.sv
// config_accumulator
//   Accumulates the signed product stream of the 4-bit shift-adder multiplier
//   into a dot-product result. In full precision it is one wide signed
//   accumulator. In halved precision the product carries two independent
//   signed half-width results that are summed in two carry-isolated lanes.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   acc_len           products per group (0 is treated as 1), sampled on first beat
//   halvedPrecision   1 = two-lane mode, 0 = full-width mode, sampled on first beat
//   in_valid/in_ready product handshake (in_ready low only while a result is held)
//   product           signed product from the multiplier
//   out_valid/ready   result handshake
//   out_acc           finished sum; {hi_lane, lo_lane} in halved mode
//   out_halved        mode the held result was built in
module config_accumulator #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    input  logic                  halvedPrecision,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic                  out_halved
);
    localparam int HP = PROD_WIDTH / 2;
    localparam int HA = ACC_WIDTH / 2;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc, w_base, w_ext, w_sum;
    logic [LEN_WIDTH-1:0]   r_count, r_len, w_len_in;
    logic                   r_mode, w_mode;
    logic                   w_beat, w_last, w_take;
    logic                   r_out_valid, r_out_halved;
    logic [ACC_WIDTH-1:0]   r_out_acc;

    assign in_ready   = (r_state != S_HOLD);
    assign out_valid  = r_out_valid;
    assign out_acc    = r_out_acc;
    assign out_halved = r_out_halved;

    assign w_beat   = in_valid && in_ready;
    assign w_take   = r_out_valid && out_ready;
    assign w_len_in = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;

    // On the first beat the live mode input applies; afterwards the latched one.
    assign w_mode = (r_state == S_IDLE) ? halvedPrecision : r_mode;
    // A group always starts from zero, so the first beat ignores r_acc.
    assign w_base = (r_state == S_IDLE) ? '0 : r_acc;

    always_comb begin
        w_ext = '0;
        w_sum = '0;
        if (w_mode) begin
            // Separate lane adds: no carry can cross from lo into hi.
            w_ext[HA-1:0]         = HA'($signed(product[HP-1:0]));
            w_ext[ACC_WIDTH-1:HA] = HA'($signed(product[PROD_WIDTH-1:HP]));
            w_sum[HA-1:0]         = w_base[HA-1:0] + w_ext[HA-1:0];
            w_sum[ACC_WIDTH-1:HA] = w_base[ACC_WIDTH-1:HA] + w_ext[ACC_WIDTH-1:HA];
        end else begin
            w_ext = ACC_WIDTH'($signed(product));
            w_sum = w_base + w_ext;
        end
    end

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_IDLE:  w_last = (w_len_in == LEN_WIDTH'(1));
            S_ACCUM: w_last = ((r_count + LEN_WIDTH'(1)) == r_len);
            default: w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: if (w_beat) w_state_nxt = w_last ? S_HOLD : S_ACCUM;
            S_HOLD:          if (w_take) w_state_nxt = S_IDLE;
            default:         w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_len        <= LEN_WIDTH'(1);
            r_mode       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_acc    <= '0;
            r_out_halved <= 1'b0;
        end else begin
            if (w_beat) begin
                r_acc <= w_sum;
                if (r_state == S_IDLE) begin
                    r_count <= LEN_WIDTH'(1);
                    r_len   <= w_len_in;
                    r_mode  <= halvedPrecision;
                end else begin
                    r_count <= r_count + LEN_WIDTH'(1);
                end
                // Result is captured on the final beat so it is valid next cycle.
                if (w_last) begin
                    r_out_acc    <= w_sum;
                    r_out_valid  <= 1'b1;
                    r_out_halved <= w_mode;
                end
            end
            if (r_state == S_HOLD && w_take) begin
                r_out_valid <= 1'b0;
                r_acc       <= '0;
                r_count     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_config_accumulator.sv
module tb_config_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  acc_len;
    logic        halvedPrecision;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc;
    logic        out_halved;

    int checks = 0;
    int errors = 0;
    logic [7:0] q_prod[$];

    config_accumulator #(.PROD_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .acc_len(acc_len), .halvedPrecision(halvedPrecision),
        .in_valid(in_valid), .in_ready(in_ready), .product(product),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_halved(out_halved)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  len;
        bit          hv;
        logic [7:0]  p;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic over the whole group, wrapped at the end.
    function automatic logic [15:0] model(input int n, input bit hv);
        int s = 0, hi = 0, lo = 0;
        logic [15:0] r;
        for (int i = 0; i < n; i++) begin
            s  += int'($signed(q_prod[i]));
            hi += (q_prod[i][7:4] >= 8) ? int'(q_prod[i][7:4]) - 16 : int'(q_prod[i][7:4]);
            lo += (q_prod[i][3:0] >= 8) ? int'(q_prod[i][3:0]) - 16 : int'(q_prod[i][3:0]);
        end
        if (hv) r = {hi[7:0], lo[7:0]};
        else    r = s[15:0];
        return r;
    endfunction

    // Feeds q_prod as one group, with random gaps and garbage mode/length after
    // the first beat, then holds the result for bp cycles before accepting it.
    task automatic do_group(input string nm, input logic [4:0] len, input bit hv,
                            input int gmin, input int gmax, input int bp,
                            input logic [15:0] exp);
        int n = (len == 0) ? 1 : int'(len);
        int early = 0;
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int g = $urandom_range(gmax, gmin);
                repeat (g) begin
                    in_valid = 1'b0;
                    product  = 8'($urandom);
                    @(posedge clk); #1;
                    if (out_valid !== 1'b0) early++;
                end
            end
            in_valid        = 1'b1;
            product         = q_prod[i];
            acc_len         = (i == 0) ? len : 5'($urandom);
            halvedPrecision = (i == 0) ? hv : ~hv;
            @(posedge clk); #1;
            if (i < n - 1 && out_valid !== 1'b0) early++;
        end
        in_valid = 1'b0;
        chk({nm, ".early"},  early, 0);
        chk({nm, ".valid"},  out_valid, 1);
        chk({nm, ".ready0"}, in_ready, 0);
        chk({nm, ".acc"},    out_acc, exp);
        chk({nm, ".halved"}, out_halved, hv);
        repeat (bp) begin
            in_valid = 1'b1;
            product  = 8'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_acc !== exp || in_ready !== 1'b0 ||
                out_halved !== hv) bad++;
        end
        if (bp > 0) chk({nm, ".hold"}, bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({nm, ".drop"},   out_valid, 0);
        chk({nm, ".ready1"}, in_ready, 1);
    endtask

    task automatic fill_const(input int n, input logic [7:0] p);
        q_prod.delete();
        for (int i = 0; i < n; i++) q_prod.push_back(p);
    endtask

    initial begin
        tbl[0] = '{5'd3,  1'b0, 8'd9,   16'd27};
        tbl[1] = '{5'd31, 1'b0, 8'd127, 16'd3937};
        tbl[2] = '{5'd31, 1'b1, 8'h70,  16'hD900};
        tbl[3] = '{5'd1,  1'b0, 8'hFF,  16'hFFFF};
        tbl[4] = '{5'd0,  1'b0, 8'h85,  16'hFF85};
        tbl[5] = '{5'd2,  1'b1, 8'h88,  16'hF0F0};
        tbl[6] = '{5'd4,  1'b0, 8'h80,  16'hFE00};
        tbl[7] = '{5'd31, 1'b1, 8'hFF,  16'hE1E1};
        tbl[8] = '{5'd16, 1'b1, 8'h77,  16'h7070};

        rst = 1'b1; acc_len = 5'd1; halvedPrecision = 1'b0;
        in_valid = 1'b0; product = 8'd0; out_ready = 1'b0;
        #12;
        chk("rst.valid",  out_valid, 0);
        chk("rst.acc",    out_acc, 0);
        chk("rst.halved", out_halved, 0);
        chk("rst.ready",  in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // 9, -9, 9 back to back
        q_prod = '{8'd9, 8'hF7, 8'd9};
        do_group("t1", 5'd3, 1'b0, 0, 0, 0, 16'd9);
        // two-lane signs
        q_prod = '{8'hF1, 8'h2E};
        do_group("t2", 5'd2, 1'b1, 0, 0, 0, 16'h01FF);
        // backpressure
        q_prod = '{8'd9, 8'hF7, 8'd9};
        do_group("t3", 5'd3, 1'b0, 0, 0, 5, 16'd9);
        // gaps with garbage mode/len after first beat
        q_prod = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_group("t5", 5'd4, 1'b0, 2, 2, 0, 16'd10);

        for (int i = 0; i < 9; i++) begin
            fill_const((tbl[i].len == 0) ? 1 : int'(tbl[i].len), tbl[i].p);
            do_group($sformatf("tbl%0d", i), tbl[i].len, tbl[i].hv, 0, 1, i % 3, tbl[i].exp);
        end

        // reset mid-group discards partial sum
        acc_len = 5'd4; halvedPrecision = 1'b0; product = 8'd5; in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rst = 1'b1; #1;
        chk("t6.valid", out_valid, 0);
        chk("t6.ready", in_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        q_prod = '{8'hFF};
        do_group("t6", 5'd1, 1'b0, 0, 0, 0, 16'hFFFF);

        // reset while a result is held
        acc_len = 5'd1; halvedPrecision = 1'b1; product = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rh.valid1", out_valid, 1);
        rst = 1'b1; #1;
        chk("rh.valid0", out_valid, 0);
        chk("rh.acc",    out_acc, 0);
        chk("rh.halved", out_halved, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // randomized groups against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [4:0]  len;
            bit          hv;
            int          n;
            logic [15:0] e;
            len = (k % 4 == 0) ? 5'($urandom_range(31, 0)) : 5'($urandom_range(6, 0));
            hv  = 1'($urandom);
            n   = (len == 0) ? 1 : int'(len);
            q_prod.delete();
            for (int j = 0; j < n; j++) q_prod.push_back(8'($urandom));
            e = model(n, hv);
            do_group($sformatf("rnd%0d", k), len, hv, 0, 2, $urandom_range(3, 0), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
